hkspi_master: RTL and testbench
===============================

# hkspi_master

Housekeeping-SPI initiator: turns parallel register read/write requests into mode-0 SPI streaming transactions (command byte, address byte, N data bytes) aimed at the chip's housekeeping SPI responder. Used on the test/bring-up side to read IDs and configuration registers and to write them, without relying on firmware. Byte-level handshakes on the user side. All SPI timing is derived from the system clock by a programmable divider.

## Interface
- CLKDIV, 2: SCK half-period in `clock` cycles; must be ≥1.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  request present.
- cmd_ready  out  1  high only in IDLE; a transfer starts when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write stream (command 0x80), 0 = read stream (command 0x40).
- cmd_addr  in  8  start register address; the responder auto-increments.
- cmd_nbytes  in  4  data byte count, 1..15; 0 means 16.
- wr_data  in  8  next write byte.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  one-cycle pulse when wr_data is accepted.
- rd_data  out  8  last received byte; held until next rd_valid.
- rd_valid  out  1  one-cycle pulse per received byte; no backpressure.
- done  out  1  one-cycle pulse when CSB returns high.
- busy  out  1  high from accept until return to IDLE.
- csb  out  1  SPI chip select, active low.
- sck  out  1  SPI clock, idle low.
- sdo  out  1  to responder SDI, MSB first.
- sdi  in  1  from responder SDO.

## Operation
- Reset values: csb=1, sck=0, sdo=0, cmd_ready=1 once reset deasserts, wr_ready=0, rd_valid=0, rd_data=0x00, done=0, busy=0.
- On accept, latch cmd_write, cmd_addr, and nbytes (0→16). The command byte is 0x80 or 0x40.
- States: IDLE → SETUP → CMD → ADDR → DATA (→ WSTALL) → HOLD → GAP → IDLE.
- Bit cell, 2×CLKDIV cycles:
  - sck is low for CLKDIV cycles, and sdo updates on entry to the low phase.
  - sck is then high for CLKDIV cycles.
  - sdi is sampled in the cycle sck rises.
- CMD and ADDR each shift 8 bits out. In read mode, sdo=0 during DATA, and sdi bits are shifted in.
- Write mode, at each data-byte boundary (before its first low phase):
  - If wr_valid=1: capture wr_data and pulse wr_ready.
  - Otherwise go to WSTALL, holding sck=0 and csb=0 until wr_valid. The byte starts the cycle after capture.
- Read mode: after the 8th bit's sample, load rd_data and pulse rd_valid in the next cycle.
- The byte counter decrements per data byte. After the last byte, go to HOLD.
- cmd_* inputs are ignored while busy. wr_valid is ignored in read mode and outside byte boundaries.
- Reset asserted mid-transaction: immediately force csb=1 and sck=0 and return to reset values. No done pulse is issued, and partial bytes are discarded.

## Timing
- SETUP: csb falls in the cycle after accept, then CLKDIV cycles pass before the first bit cell.
- HOLD: sck low for CLKDIV cycles after the last high phase, then csb rises and done pulses in the same cycle.
- GAP: csb stays high for 2×CLKDIV cycles. cmd_ready rises at the end of GAP.
- Unstalled transaction, from accept to done: 1 + CLKDIV + 16·CLKDIV·(2+N) + CLKDIV cycles.
- Back-to-back spacing, accept to next accept: that figure + 2·CLKDIV + 1.
- Divider counter width: clog2(CLKDIV)+1. The bit counter is 3 bits and the byte counter is 5 bits.

## Test plan
- Read, addr 0x01, nbytes 1, CLKDIV=2, responder returns 0x04:
  - MOSI shows 0x40, 0x01.
  - One rd_valid with rd_data=0x04.
  - done exactly 1+2+96+2=101 cycles after accept.
- Stream read, addr 0x01, nbytes 3:
  - rd_data sequence 0x04, 0x56, 0x10.
  - 3 rd_valid pulses, csb low continuously.
- Stream write, addr 0x08, nbytes 2, data 0x01 then 0xFF, wr_valid withheld 50 cycles before byte 2:
  - MOSI shows 0x80, 0x08, 0x01, 0xFF.
  - sck=0 and csb=0 throughout the stall, and 2 wr_ready pulses.
- nbytes=0:
  - 16 data bytes are transferred, giving 16 rd_valid pulses.
- Reset asserted mid-ADDR:
  - csb=1 and sck=0 the same cycle, with no done or rd_valid.
  - After release, a read of 0x03 returns 0x10.
- CLKDIV=1 with back-to-back reads (cmd_valid held high):
  - csb high exactly 2 cycles between transactions.
  - cmd_ready is low whenever busy=1.

Source files
------------

// File: rtl/hkspi_master.sv
// Housekeeping-SPI initiator: parallel register read/write requests become
// mode-0 SPI streams (command, address, N data bytes) timed by CLKDIV.
module hkspi_master #(
  parameter int CLKDIV = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [3:0] cmd_nbytes,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic       busy,
  output logic       csb,
  output logic       sck,
  output logic       sdo,
  input  logic       sdi
);

  localparam int DW = $clog2(CLKDIV) + 1;
  localparam logic [DW-1:0] DLAST = DW'(CLKDIV - 1);
  localparam logic [DW-1:0] DSET  = DW'(CLKDIV);
  localparam logic [DW-1:0] GLAST = DW'(2 * CLKDIV - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_WSTALL,
    S_HOLD,
    S_GAP
  } state_t;

  state_t        state;
  logic [DW-1:0] div;
  logic [2:0]    bitcnt;
  logic [4:0]    bytecnt;
  logic [7:0]    sh;
  logic [7:0]    rx;
  logic [7:0]    addr_q;
  logic          wmode;
  logic          rd_pend;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      div       <= '0;
      bitcnt    <= '0;
      bytecnt   <= '0;
      sh        <= '0;
      rx        <= '0;
      addr_q    <= '0;
      wmode     <= 1'b0;
      rd_pend   <= 1'b0;
      cmd_ready <= 1'b1;
      wr_ready  <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      csb       <= 1'b1;
      sck       <= 1'b0;
      sdo       <= 1'b0;
    end else begin
      wr_ready <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      // received byte surfaces one cycle after its last sample
      if (rd_pend) begin
        rd_pend  <= 1'b0;
        rd_valid <= 1'b1;
        rd_data  <= rx;
      end
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            csb       <= 1'b0;
            wmode     <= cmd_write;
            addr_q    <= cmd_addr;
            bytecnt   <= (cmd_nbytes == 4'd0) ? 5'd16
                                              : {1'b0, cmd_nbytes};
            sh        <= cmd_write ? 8'h80 : 8'h40;
            div       <= '0;
            bitcnt    <= '0;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (div == DSET) begin
            div   <= '0;
            sdo   <= sh[7];
            sh    <= {sh[6:0], 1'b0};
            state <= S_CMD;
          end else begin
            div <= div + DW'(1);
          end
        end
        S_CMD, S_ADDR, S_DATA: begin
          if (!sck) begin
            if (div == DLAST) begin
              sck <= 1'b1;
              div <= '0;
            end else begin
              div <= div + DW'(1);
            end
          end else begin
            if (div == '0) begin
              rx <= {rx[6:0], sdi};
              if (state == S_DATA && !wmode && bitcnt == 3'd7)
                rd_pend <= 1'b1;
            end
            if (div == DLAST) begin
              sck    <= 1'b0;
              div    <= '0;
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt != 3'd7) begin
                sdo <= sh[7];
                sh  <= {sh[6:0], 1'b0};
              end else begin
                if (state == S_DATA)
                  bytecnt <= bytecnt - 5'd1;
                unique case (1'b1)
                  (state == S_CMD): begin
                    sdo   <= addr_q[7];
                    sh    <= {addr_q[6:0], 1'b0};
                    state <= S_ADDR;
                  end
                  (state == S_DATA && bytecnt == 5'd1): begin
                    sdo   <= 1'b0;
                    state <= S_HOLD;
                  end
                  default: begin
                    if (!wmode) begin
                      sdo   <= 1'b0;
                      sh    <= '0;
                      state <= S_DATA;
                    end else if (wr_valid) begin
                      wr_ready <= 1'b1;
                      sdo      <= wr_data[7];
                      sh       <= {wr_data[6:0], 1'b0};
                      state    <= S_DATA;
                    end else begin
                      state <= S_WSTALL;
                    end
                  end
                endcase
              end
            end else begin
              div <= div + DW'(1);
            end
          end
        end
        S_WSTALL: begin
          if (wr_valid) begin
            wr_ready <= 1'b1;
            sdo      <= wr_data[7];
            sh       <= {wr_data[6:0], 1'b0};
            div      <= '0;
            state    <= S_DATA;
          end
        end
        S_HOLD: begin
          if (div == DLAST) begin
            csb   <= 1'b1;
            done  <= 1'b1;
            div   <= '0;
            state <= S_GAP;
          end else begin
            div <= div + DW'(1);
          end
        end
        S_GAP: begin
          // the IDLE cycle completes the csb-high gap
          if (div == GLAST) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            div       <= '0;
            state     <= S_IDLE;
          end else begin
            div <= div + DW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hkspi_master.sv
// Bench for hkspi_master: SPI responder model, MOSI/read scoreboards,
// vector table, reset-abort and CLKDIV=1 back-to-back sequences.
module tb_hkspi_master;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr;
  logic [3:0] cmd_nbytes;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid, done, busy, csb, sck, sdo;
  logic       sdi = 1'b0;

  logic       c1_valid, c1_ready;
  logic [7:0] rd_data1;
  logic       wr_ready1, rd_valid1, done1, busy1, csb1, sck1, sdo1;
  logic       sdi1 = 1'b0;

  always #5 clock = ~clock;

  hkspi_master #(.CLKDIV(2)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_nbytes(cmd_nbytes),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .busy(busy),
    .csb(csb), .sck(sck), .sdo(sdo), .sdi(sdi)
  );

  hkspi_master #(.CLKDIV(1)) dut1 (
    .clock(clock), .reset(reset),
    .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_write(1'b0), .cmd_addr(8'h02),
    .cmd_nbytes(4'd1),
    .wr_data(8'h00), .wr_valid(1'b0), .wr_ready(wr_ready1),
    .rd_data(rd_data1), .rd_valid(rd_valid1),
    .done(done1), .busy(busy1),
    .csb(csb1), .sck(sck1), .sdo(sdo1), .sdi(sdi1)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] memv(input logic [7:0] a);
    case (a)
      8'h01:   return 8'h04;
      8'h02:   return 8'h56;
      8'h03:   return 8'h10;
      default: return a ^ 8'hA5;
    endcase
  endfunction

  always @(posedge clock) cyc++;

  logic [7:0] exp_mosi[$];
  logic [7:0] exp_rd[$];
  logic [7:0] wq[$];

  int rises = 0;
  int csb_rises = 0;
  logic [7:0] mbits = 8'h00;
  logic [7:0] raddr = 8'h00;

  // MOSI capture and responder address decode
  always @(posedge sck or posedge csb) begin
    if (csb) begin
      rises = 0;
      csb_rises++;
    end else begin
      mbits = {mbits[6:0], sdo};
      rises++;
      if (rises == 16) raddr = mbits;
      if (rises % 8 == 0) begin
        if (exp_mosi.size() == 0)
          chk("mosi_q_nonempty", exp_mosi.size(), 1);
        else
          chk("mosi_byte", mbits, exp_mosi.pop_front());
      end
    end
  end

  // responder drives next read bit on sck fall
  always @(negedge sck) begin
    int k;
    logic [7:0] b;
    if (rises >= 16) begin
      k = rises - 16;
      b = memv(raddr + 8'(k / 8));
      sdi <= b[7 - (k % 8)];
    end
  end

  int rdv_cnt = 0;
  int done_cnt = 0;
  always @(negedge clock) begin
    if (rd_valid) begin
      rdv_cnt++;
      if (exp_rd.size() == 0)
        chk("rd_q_nonempty", exp_rd.size(), 1);
      else
        chk("rd_byte", rd_data, exp_rd.pop_front());
    end
    if (done) done_cnt++;
  end

  int wr_cnt = 0;
  int wr_base = 0;
  int stall_at = -1;
  int stall_left = 0;
  int stall_chk = 0;
  int stall_bad = 0;
  initial begin
    wr_valid = 1'b0;
    wr_data = 8'h00;
    forever begin
      @(negedge clock);
      if (wr_ready) begin
        wr_cnt++;
        if (wq.size() > 0) void'(wq.pop_front());
        if (wr_cnt - wr_base == stall_at) stall_left = 50;
      end
      if (stall_left > 0) begin
        if (stall_left <= 15) begin
          stall_chk++;
          if (sck !== 1'b0 || csb !== 1'b0) stall_bad++;
        end
        stall_left--;
      end
      wr_valid = (wq.size() > 0 && stall_left == 0);
      wr_data = (wq.size() > 0) ? wq[0] : 8'h00;
    end
  end

  // CLKDIV=1 back-to-back monitor
  bit b2b_on = 1'b0;
  bit seen_low = 1'b0;
  int hrun = 0;
  int b2b_viol = 0;
  int done1_cnt = 0;
  int acc_t = 0;
  int gaps[$];
  int lats1[$];
  always @(negedge clock) begin
    if (b2b_on) begin
      if (c1_ready && busy1) b2b_viol++;
      if (c1_ready && c1_valid) acc_t = cyc + 1;
      if (done1) begin
        done1_cnt++;
        lats1.push_back(cyc - acc_t);
      end
      if (csb1) hrun++;
      else begin
        if (seen_low && hrun > 0) gaps.push_back(hrun);
        hrun = 0;
        seen_low = 1'b1;
      end
    end
  end

  task automatic issue(input bit w, input logic [7:0] a,
                       input logic [3:0] nb, output int t0);
    bit ok = 1'b0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clock);
      ok = cmd_ready;
    end
    if (!ok) chk("ready_timeout", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_nbytes = nb;
    @(posedge clock);
    #1;
    t0 = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic run_txn(input bit w, input logic [7:0] a,
                         input logic [3:0] nb,
                         input logic [3:0][7:0] wd,
                         input int st, output int lat);
    int n;
    int t0;
    bit ok = 1'b0;
    n = (nb == 4'd0) ? 16 : int'(nb);
    exp_mosi.push_back(w ? 8'h80 : 8'h40);
    exp_mosi.push_back(a);
    wq.delete();
    for (int i = 0; i < n; i++) begin
      if (w) begin
        exp_mosi.push_back(wd[i % 4]);
        wq.push_back(wd[i % 4]);
      end else begin
        exp_mosi.push_back(8'h00);
        exp_rd.push_back(memv(a + 8'(i)));
      end
    end
    wr_base = wr_cnt;
    stall_at = st;
    issue(w, a, nb, t0);
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clock);
      ok = done;
    end
    lat = ok ? cyc - t0 : -1;
    if (!ok) chk("done_timeout", done, 1);
    repeat (6) @(negedge clock);
  endtask

  typedef struct {
    bit              w;
    logic [7:0]      a;
    logic [3:0]      nb;
    logic [3:0][7:0] wd;
    int              st;
    int              lat;
    int              nrd;
    int              nwr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat, d0, r0, w0, c0, s0, b0, t0;
    bit ok;
    vecs[0] = '{0, 8'h01, 4'd1, 32'h0, -1, 101, 1, 0};
    vecs[1] = '{0, 8'h01, 4'd3, 32'h0, -1, 165, 3, 0};
    vecs[2] = '{1, 8'h08, 4'd2, 32'h0000FF01, 1, -1, 0, 2};
    vecs[3] = '{0, 8'h20, 4'd0, 32'h0, -1, 581, 16, 0};
    vecs[4] = '{1, 8'h10, 4'd3, 32'h00563412, -1, 165, 0, 3};
    vecs[5] = '{0, 8'hFE, 4'd2, 32'h0, -1, 133, 2, 0};

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = 8'h00;
    cmd_nbytes = 4'd0;
    c1_valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_state",
        {csb, sck, sdo, cmd_ready, wr_ready, rd_valid, done, busy, rd_data},
        16'h9000);

    foreach (vecs[i]) begin
      d0 = done_cnt; r0 = rdv_cnt; w0 = wr_cnt; c0 = csb_rises;
      s0 = stall_chk; b0 = stall_bad;
      run_txn(vecs[i].w, vecs[i].a, vecs[i].nb, vecs[i].wd,
              vecs[i].st, lat);
      if (vecs[i].lat >= 0) chk("latency", lat, vecs[i].lat);
      chk("rd_count", rdv_cnt - r0, vecs[i].nrd);
      chk("wr_count", wr_cnt - w0, vecs[i].nwr);
      chk("done_count", done_cnt - d0, 1);
      chk("csb_rises", csb_rises - c0, 1);
      chk("rd_left", exp_rd.size(), 0);
      chk("mosi_left", exp_mosi.size(), 0);
      if (vecs[i].st >= 0) begin
        chk("stall_window", stall_chk - s0, 15);
        chk("stall_idle", stall_bad - b0, 0);
      end
    end

    // reset during the address byte
    exp_mosi.push_back(8'h40);
    wq.delete();
    stall_at = -1;
    issue(1'b0, 8'h01, 4'd1, t0);
    ok = 1'b0;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(negedge clock);
      ok = (rises >= 12);
    end
    if (!ok) chk("reach_addr", rises, 12);
    d0 = done_cnt;
    r0 = rdv_cnt;
    reset = 1'b1;
    #1;
    chk("abort_csb", csb, 1);
    chk("abort_sck", sck, 0);
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_no_rd", rdv_cnt - r0, 0);
    chk("abort_mosi_left", exp_mosi.size(), 0);
    chk("abort_idle", {busy, cmd_ready}, 2'b01);
    d0 = done_cnt;
    r0 = rdv_cnt;
    run_txn(1'b0, 8'h03, 4'd1, 32'h0, -1, lat);
    chk("post_abort_lat", lat, 101);
    chk("post_abort_rd", rdv_cnt - r0, 1);
    chk("post_abort_rd_left", exp_rd.size(), 0);

    // CLKDIV=1 back-to-back reads
    b2b_on = 1'b1;
    c1_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clock);
      ok = (done1_cnt >= 3);
    end
    c1_valid = 1'b0;
    if (!ok) chk("b2b_timeout", done1_cnt, 3);
    repeat (10) @(negedge clock);
    chk("b2b_done", done1_cnt, 3);
    chk("b2b_gaps", gaps.size(), 2);
    for (int i = 0; i < gaps.size(); i++)
      chk("b2b_gap_len", gaps[i], 2);
    chk("b2b_ready_busy", b2b_viol, 0);
    if (lats1.size() > 0) chk("b2b_latency", lats1[0], 51);
    chk("b2b_idle", {busy1, c1_ready, csb1}, 3'b011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
